// File: rtl/fft_spi_pkg.sv
// Shared types and defaults for the two-channel SPI-to-FFT arbiter.
package fft_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int unsigned DEF_BIT_WIDTH = 32;
  localparam int unsigned DEF_N_SAMPLES = 8;

endpackage

// File: rtl/fft_arb_rr2.sv
// Two-way round-robin picker: on a tie the channel that did not own the last frame wins.
module fft_arb_rr2
  import fft_spi_pkg::*;
(
  input  logic [1:0] val,
  input  logic       last,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any = |val;
    if (&val) begin
      grant = (last == CH0) ? CH1 : CH0;
    end else begin
      grant = val[1] ? CH1 : CH0;
    end
  end

endmodule

// File: rtl/fft_spi_arbiter.sv
// Grants the FFT core to one SPI channel per frame: load N_SAMPLES words in, drain N_SAMPLES
// results back to the same channel, then re-arbitrate round-robin.
module fft_spi_arbiter
  import fft_spi_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int unsigned N_SAMPLES = DEF_N_SAMPLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] req0_msg,
  input  logic                 req0_val,
  output logic                 req0_rdy,
  input  logic [BIT_WIDTH-1:0] req1_msg,
  input  logic                 req1_val,
  output logic                 req1_rdy,
  output logic [BIT_WIDTH-1:0] resp0_msg,
  output logic                 resp0_val,
  input  logic                 resp0_rdy,
  output logic [BIT_WIDTH-1:0] resp1_msg,
  output logic                 resp1_val,
  input  logic                 resp1_rdy,
  output logic [BIT_WIDTH-1:0] fft_in_msg,
  output logic                 fft_in_val,
  input  logic                 fft_in_rdy,
  input  logic [BIT_WIDTH-1:0] fft_out_msg,
  input  logic                 fft_out_val,
  output logic                 fft_out_rdy,
  output logic                 owner,
  output logic                 busy,
  output logic [15:0]          frame_cnt
);

  localparam int unsigned CNT_W = $clog2(N_SAMPLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

  state_t           state, state_n;
  logic             owner_n;
  logic             last, last_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [15:0]      frame_cnt_n;
  logic             grant, any;
  logic             in_fire, out_fire;

  fft_arb_rr2 u_rr (
    .val   ({req1_val, req0_val}),
    .last  (last),
    .grant (grant),
    .any   (any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= CH0;
      last      <= CH1;
      cnt       <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      last      <= last_n;
      cnt       <= cnt_n;
      frame_cnt <= frame_cnt_n;
    end
  end

  // Next-state logic plus the zero-latency val/rdy/msg muxes toward the owning channel.
  always_comb begin
    state_n     = state;
    owner_n     = owner;
    last_n      = last;
    cnt_n       = cnt;
    frame_cnt_n = frame_cnt;
    req0_rdy    = 1'b0;
    req1_rdy    = 1'b0;
    resp0_msg   = '0;
    resp0_val   = 1'b0;
    resp1_msg   = '0;
    resp1_val   = 1'b0;
    fft_in_msg  = '0;
    fft_in_val  = 1'b0;
    fft_out_rdy = 1'b0;
    in_fire     = 1'b0;
    out_fire    = 1'b0;

    unique case (state)
      IDLE: begin
        if (any) begin
          state_n = LOAD;
          owner_n = grant;
        end
      end
      LOAD: begin
        if (owner == CH1) begin
          fft_in_msg = req1_msg;
          fft_in_val = req1_val;
          req1_rdy   = fft_in_rdy;
        end else begin
          fft_in_msg = req0_msg;
          fft_in_val = req0_val;
          req0_rdy   = fft_in_rdy;
        end
        in_fire = fft_in_val & fft_in_rdy;
        if (in_fire) begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = DRAIN;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (owner == CH1) begin
          resp1_msg   = fft_out_msg;
          resp1_val   = fft_out_val;
          fft_out_rdy = resp1_rdy;
        end else begin
          resp0_msg   = fft_out_msg;
          resp0_val   = fft_out_val;
          fft_out_rdy = resp0_rdy;
        end
        out_fire = fft_out_val & fft_out_rdy;
        if (out_fire) begin
          if (cnt == CNT_LAST) begin
            cnt_n       = '0;
            last_n      = owner;
            frame_cnt_n = frame_cnt + 16'd1;
            state_n     = IDLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fft_spi_arbiter.sv
// Scoreboard bench for fft_spi_arbiter: sources feed both channels, a simple FFT model returns x+100.
module tb_fft_spi_arbiter;

  localparam int unsigned BW = 32;
  localparam int unsigned N  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [BW-1:0] req0_msg, req1_msg, resp0_msg, resp1_msg;
  logic          req0_val, req0_rdy, req1_val, req1_rdy;
  logic          resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [BW-1:0] fft_in_msg, fft_out_msg;
  logic          fft_in_val, fft_in_rdy, fft_out_val, fft_out_rdy;
  logic          owner, busy;
  logic [15:0]   frame_cnt;

  fft_spi_arbiter #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
    .clk(clk), .reset(reset),
    .req0_msg(req0_msg), .req0_val(req0_val), .req0_rdy(req0_rdy),
    .req1_msg(req1_msg), .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .fft_in_msg(fft_in_msg), .fft_in_val(fft_in_val), .fft_in_rdy(fft_in_rdy),
    .fft_out_msg(fft_out_msg), .fft_out_val(fft_out_val), .fft_out_rdy(fft_out_rdy),
    .owner(owner), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [BW-1:0] src0_q[$], src1_q[$], fft_q[$];
  logic [BW:0]   exp_q[$];
  bit en0 = 1'b1, en1 = 1'b1, in_stall = 1'b0, rstall0 = 1'b0, rstall1 = 1'b0;
  bit prev_busy = 1'b0, drain_seen = 1'b0;
  int idle_len = 0, frame_in = 0, resp_hs = 0, resp1_seen = 0;
  int owner_log[$], gap_log[$];

  // One clock cycle: drive at negedge, evaluate handshakes and scoreboard before the posedge.
  task automatic tick();
    logic [BW-1:0] x;
    logic [BW:0]   e;
    @(negedge clk);
    req0_val    = en0 && (src0_q.size() != 0);
    req0_msg    = req0_val ? src0_q[0] : '0;
    req1_val    = en1 && (src1_q.size() != 0);
    req1_msg    = req1_val ? src1_q[0] : '0;
    fft_in_rdy  = !in_stall;
    fft_out_val = (fft_q.size() != 0);
    fft_out_msg = fft_out_val ? fft_q[0] : '0;
    resp0_rdy   = !rstall0;
    resp1_rdy   = !rstall1;
    #1;
    if (busy && !prev_busy) begin
      owner_log.push_back(int'(owner));
      gap_log.push_back(idle_len);
      idle_len   = 0;
      frame_in   = 0;
      drain_seen = 1'b0;
    end else if (!busy) begin
      idle_len++;
    end
    prev_busy = busy;
    if (resp1_val) resp1_seen++;

    n_checks++;
    if ((req0_rdy && req1_rdy) || (resp0_val && resp1_val))
      $display("FAIL exclusive: req_rdy=%b%b resp_val=%b%b required at most one each",
               req1_rdy, req0_rdy, resp1_val, resp0_val);
    if (fft_out_rdy && !drain_seen) begin
      drain_seen = 1'b1;
      n_checks++;
      if (frame_in != int'(N)) begin
        n_fail++;
        $display("FAIL drain_entry: loaded %0d words, required %0d", frame_in, N);
      end
    end

    if (req0_val && req0_rdy) begin
      x = src0_q.pop_front();
      exp_q.push_back({1'b0, 32'(x + 32'd100)});
    end
    if (req1_val && req1_rdy) begin
      x = src1_q.pop_front();
      exp_q.push_back({1'b1, 32'(x + 32'd100)});
    end
    if (fft_in_val && fft_in_rdy) begin
      fft_q.push_back(32'(fft_in_msg + 32'd100));
      frame_in++;
    end
    if (fft_out_val && fft_out_rdy) void'(fft_q.pop_front());
    if (resp0_val && resp0_rdy) begin
      resp_hs++;
      n_checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : {1'b1, 32'hDEAD_BEEF};
      if ({1'b0, resp0_msg} !== e) begin
        n_fail++;
        $display("FAIL resp0_word: got ch0/%0h, required ch%0d/%0h", resp0_msg, e[BW], e[BW-1:0]);
      end
    end
    if (resp1_val && resp1_rdy) begin
      resp_hs++;
      n_checks++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : {1'b0, 32'hDEAD_BEEF};
      if ({1'b1, resp1_msg} !== e) begin
        n_fail++;
        $display("FAIL resp1_word: got ch1/%0h, required ch%0d/%0h", resp1_msg, e[BW], e[BW-1:0]);
      end
    end
  endtask

  task automatic clear_model();
    src0_q.delete(); src1_q.delete(); fft_q.delete(); exp_q.delete();
    owner_log.delete(); gap_log.delete();
    prev_busy = 1'b0; drain_seen = 1'b0; idle_len = 0; frame_in = 0; resp_hs = 0;
    en0 = 1'b1; en1 = 1'b1; in_stall = 1'b0; rstall0 = 1'b0; rstall1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req0_val = 1'b0; req1_val = 1'b0; fft_out_val = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_model();
  endtask

  // Tick until all sources, scoreboard and the DUT are quiet.
  task automatic run_frames(input int budget, input string name);
    int c = 0;
    do begin
      tick();
      c++;
    end while ((src0_q.size() != 0 || src1_q.size() != 0 || exp_q.size() != 0 || busy) && c < budget);
    n_checks++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, c);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0_val = 1'b1; req0_msg = 32'h5; req1_val = 1'b1; req1_msg = 32'h6;
    fft_in_rdy = 1'b1; fft_out_val = 1'b1; fft_out_msg = 32'h7;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({req0_rdy, req1_rdy, fft_in_val, fft_out_rdy, resp0_val, resp1_val} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b, required 000000",
               {req0_rdy, req1_rdy, fft_in_val, fft_out_rdy, resp0_val, resp1_val});
    end
    n_checks++;
    if (owner !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: owner=%b busy=%b frame_cnt=%0d, required 0 0 0", owner, busy, frame_cnt);
    end
    @(negedge clk);
    req0_val = 1'b0; req1_val = 1'b0; fft_out_val = 1'b0;
    reset = 1'b1;
    clear_model();
  endtask

  task automatic test_single_ch0();
    resp1_seen = 0;
    for (int i = 1; i <= 8; i++) src0_q.push_back(32'(i));
    tick();
    n_checks++;
    if (busy !== 1'b0 || req0_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_idle_cycle: busy=%b req0_rdy=%b, required 0 0", busy, req0_rdy);
    end
    tick();
    n_checks++;
    if (busy !== 1'b1 || owner !== 1'b0 || req0_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL arb_grant: busy=%b owner=%b req0_rdy=%b, required 1 0 1", busy, owner, req0_rdy);
    end
    run_frames(100, "single");
    n_checks++;
    if (frame_cnt !== 16'd1 || resp_hs != 8 || resp1_seen != 0) begin
      n_fail++;
      $display("FAIL single_frame: frame_cnt=%0d results=%0d resp1_valid_cycles=%0d, required 1 8 0",
               frame_cnt, resp_hs, resp1_seen);
    end
  endtask

  task automatic test_round_robin();
    int c = 0;
    do_reset();
    for (int i = 0; i < 24; i++) src0_q.push_back(32'h200 + 32'(i));
    for (int i = 0; i < 16; i++) src1_q.push_back(32'h300 + 32'(i));
    while (owner_log.size() < 5 && c < 600) begin
      tick();
      c++;
    end
    n_checks++;
    if (owner_log.size() < 5 || frame_cnt !== 16'd4 || resp_hs != 32) begin
      n_fail++;
      $display("FAIL rr_progress: frames_started=%0d frame_cnt=%0d results=%0d, required 5 4 32",
               owner_log.size(), frame_cnt, resp_hs);
    end
    for (int i = 0; i < 4 && i < owner_log.size(); i++) begin
      n_checks++;
      if (owner_log[i] != (i % 2) || gap_log[i] != 1) begin
        n_fail++;
        $display("FAIL rr_frame%0d: owner=%0d idle_cycles=%0d, required %0d 1",
                 i, owner_log[i], gap_log[i], i % 2);
      end
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    int c = 0, stall_left = 0;
    bit stall_done = 1'b0;
    logic [15:0] fc0 = frame_cnt;
    resp_hs = 0;
    for (int i = 1; i <= 8; i++) src0_q.push_back(32'h1000 + 32'(i));
    while (c < 300) begin
      in_stall = (c >= 2 && c <= 4);
      rstall0  = 1'b0;
      if (!stall_done && resp_hs == 3) begin
        stall_left = 5;
        stall_done = 1'b1;
      end
      if (stall_left > 0) begin
        rstall0 = 1'b1;
        stall_left--;
      end
      tick();
      if (rstall0) begin
        n_checks++;
        if (fft_out_rdy !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_resp_stall: fft_out_rdy=%b busy=%b, required 0 1", fft_out_rdy, busy);
        end
      end
      if (in_stall && busy) begin
        n_checks++;
        if (req0_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_stall: req0_rdy=%b, required 0", req0_rdy);
        end
      end
      c++;
      if (c > 1 && !busy && src0_q.size() == 0 && exp_q.size() == 0) break;
    end
    in_stall = 1'b0;
    rstall0  = 1'b0;
    n_checks++;
    if (c >= 300 || resp_hs != 8 || frame_cnt !== 16'(fc0 + 16'd1)) begin
      n_fail++;
      $display("FAIL bp_frame: cycles=%0d results=%0d frame_cnt=%0d, required <300 8 %0d",
               c, resp_hs, frame_cnt, fc0 + 16'd1);
    end
  endtask

  task automatic test_nonowner_pending();
    int c = 0;
    logic [15:0] fc0 = frame_cnt;
    owner_log.delete(); gap_log.delete();
    en1 = 1'b0;
    frame_in = 0;
    for (int i = 0; i < 8; i++) src0_q.push_back(32'h40 + 32'(i));
    for (int i = 0; i < 8; i++) src1_q.push_back(32'h80 + 32'(i));
    while (c < 300) begin
      if (busy && frame_in >= 2) en1 = 1'b1;
      tick();
      if (busy && owner == 1'b0 && en1) begin
        n_checks++;
        if (req1_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL pending_rdy: req1_rdy=%b during channel-0 frame, required 0", req1_rdy);
        end
      end
      c++;
      if (c > 1 && !busy && src0_q.size() == 0 && src1_q.size() == 0 && exp_q.size() == 0) break;
    end
    n_checks++;
    if (owner_log.size() != 2 || frame_cnt !== 16'(fc0 + 16'd2)) begin
      n_fail++;
      $display("FAIL pending_frames: frames=%0d frame_cnt=%0d, required 2 %0d",
               owner_log.size(), frame_cnt, fc0 + 16'd2);
    end else begin
      n_checks++;
      if (owner_log[0] != 0 || owner_log[1] != 1 || gap_log[1] != 1) begin
        n_fail++;
        $display("FAIL pending_grant: owners=%0d,%0d idle_cycles=%0d, required 0,1 1",
                 owner_log[0], owner_log[1], gap_log[1]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int c = 0;
    for (int i = 0; i < 8; i++) src1_q.push_back(32'hA0 + 32'(i));
    while (!(busy && frame_in == 3) && c < 50) begin
      tick();
      c++;
    end
    n_checks++;
    if (owner !== 1'b1 || frame_in != 3) begin
      n_fail++;
      $display("FAIL midreset_setup: owner=%b loaded=%0d, required 1 3", owner, frame_in);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({req0_rdy, req1_rdy, fft_in_val, fft_out_rdy, resp0_val, resp1_val, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got %b, required 0000000",
               {req0_rdy, req1_rdy, fft_in_val, fft_out_rdy, resp0_val, resp1_val, busy});
    end
    n_checks++;
    if (owner !== 1'b0 || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_state: owner=%b frame_cnt=%0d, required 0 0", owner, frame_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    clear_model();
    for (int i = 0; i < 8; i++) src1_q.push_back(32'hC0 + 32'(i));
    run_frames(100, "midreset");
    n_checks++;
    if (frame_cnt !== 16'd1 || resp_hs != 8) begin
      n_fail++;
      $display("FAIL midreset_refill: frame_cnt=%0d results=%0d, required 1 8", frame_cnt, resp_hs);
    end
  endtask

  task automatic test_early_out();
    int c = 0, early = 0;
    resp_hs = 0;
    for (int i = 0; i < 8; i++) src0_q.push_back(32'hE0 + 32'(i));
    while (c < 100) begin
      tick();
      if (busy && !drain_seen && fft_out_val) begin
        early++;
        n_checks++;
        if (fft_out_rdy !== 1'b0 || resp0_val !== 1'b0 || resp1_val !== 1'b0) begin
          n_fail++;
          $display("FAIL early_out: fft_out_rdy=%b resp_val=%b%b during LOAD, required 0 00",
                   fft_out_rdy, resp1_val, resp0_val);
        end
      end
      c++;
      if (c > 1 && !busy && src0_q.size() == 0 && exp_q.size() == 0) break;
    end
    n_checks++;
    if (early == 0 || resp_hs != 8) begin
      n_fail++;
      $display("FAIL early_out_frame: early_cycles=%0d results=%0d, required >0 8", early, resp_hs);
    end
  endtask

  initial begin
    test_reset();
    test_single_ch0();
    test_round_robin();
    test_backpressure();
    test_nonowner_pending();
    test_reset_midframe();
    test_early_out();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
